// File: rtl/bus_pkg.sv
// Shared types and default sizing for the serial system bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_GNT_TIMEOUT = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: the requester closest after i_last wins.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_last,
    output logic                 o_any,
    output logic [$clog2(N)-1:0] o_winner
);

    localparam int W = $clog2(N);

    int w_best;
    int w_dist;

    // Distance runs 1..N going forward from i_last, so i_last itself is checked last.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_best   = N + 1;
        w_dist   = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i > int'(i_last)) ? (i - int'(i_last)) : (i - int'(i_last) + N);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_winner = W'(i);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared serial bus: one-cycle grant, zero-latency
// steering of the owner's signals while BUSY, release on valid drop or timeout.
// Handshake: an owner transfer is "valid high at least once, then valid low";
// the cycle valid drops ends ownership. bus_ready is passed through only to the owner.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         m_breq,
    output logic [NUM_MASTERS-1:0]         m_bgnt,
    input  logic [NUM_MASTERS-1:0]         m_addr,
    input  logic [NUM_MASTERS-1:0]         m_wdata,
    input  logic [NUM_MASTERS-1:0]         m_valid,
    output logic [NUM_MASTERS-1:0]         m_ready,
    output logic                           bus_addr,
    output logic                           bus_wdata,
    output logic                           bus_valid,
    input  logic                           bus_ready,
    output logic [$clog2(NUM_MASTERS)-1:0] bus_owner,
    output logic                           bus_busy,
    output logic                           arb_timeout,
    output arb_state_t                     dbg_state
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last_owner;
    logic [CW-1:0] r_cnt;
    logic          r_seen_valid;

    logic          w_any;
    logic [OW-1:0] w_winner;
    logic          w_own_valid;
    logic          w_release;
    logic          w_timeout;

    rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
        .i_req    (m_breq),
        .i_last   (r_last_owner),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    assign w_own_valid = m_valid[r_owner];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(NUM_MASTERS - 1);
            r_cnt        <= '0;
            r_seen_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_any) begin
                r_owner <= w_winner;
            end
            if (w_release || w_timeout) begin
                r_last_owner <= r_owner;
            end
            // Counter and seen flag restart whenever we are not inside a BUSY tenure.
            if (r_state != BUSY) begin
                r_cnt        <= '0;
                r_seen_valid <= 1'b0;
            end else if (!r_seen_valid) begin
                if (w_own_valid) begin
                    r_seen_valid <= 1'b1;
                end
                if (r_cnt != {CW{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        m_bgnt       = '0;
        m_ready      = '0;
        bus_addr     = 1'b0;
        bus_wdata    = 1'b0;
        bus_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                m_bgnt[r_owner] = 1'b1;
                w_next_state    = BUSY;
            end
            BUSY: begin
                bus_addr         = m_addr[r_owner];
                bus_wdata        = m_wdata[r_owner];
                bus_valid        = w_own_valid;
                m_ready[r_owner] = bus_ready;
                if (r_seen_valid && !w_own_valid) begin
                    w_release = 1'b1;
                end else if (!r_seen_valid && !w_own_valid && (r_cnt == CNT_LAST)) begin
                    w_timeout = 1'b1;
                end
                if (w_release || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign arb_timeout = w_timeout;
    assign bus_owner   = r_owner;
    assign bus_busy    = (r_state != IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: each transfer is predicted at transaction
// level (round-robin winner, grant/busy/release timing) and checked cycle by cycle.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N  = 2;
    localparam int GT = 8;
    localparam int OW = $clog2(N);

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  m_breq;
    logic [N-1:0]  m_addr;
    logic [N-1:0]  m_wdata;
    logic [N-1:0]  m_valid;
    logic          bus_ready;
    logic [N-1:0]  m_bgnt;
    logic [N-1:0]  m_ready;
    logic          bus_addr;
    logic          bus_wdata;
    logic          bus_valid;
    logic [OW-1:0] bus_owner;
    logic          bus_busy;
    logic          arb_timeout;
    arb_state_t    dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_last;

    bus_arbiter #(.NUM_MASTERS(N), .GNT_TIMEOUT(GT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m_breq      (m_breq),
        .m_bgnt      (m_bgnt),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_owner   (bus_owner),
        .bus_busy    (bus_busy),
        .arb_timeout (arb_timeout),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- reference model ----------------
    // First requester found walking forward from last owner, wrapping modulo N.
    function automatic int rr_model(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (|(req & (N'(1) << c))) return c;
        end
        return -1;
    endfunction

    // One complete tenure: IDLE request cycle, GRANT cycle, BUSY cycles.
    // Owner asserts valid for BUSY cycles [delay, delay+len); delay >= GT means never.
    // ready_mode: 0 = ready held high, 1 = random, 2 = alternating.
    task automatic run_xfer(input logic [N-1:0] req, input int delay, input int len,
                            input int ready_mode, output int owner_seen);
        int            exp_own;
        int            end_k;
        bit            exp_to;
        logic [OW-1:0] eo;
        logic [N-1:0]  exp_rdy;

        next_cycle();
        m_breq    = req;
        m_valid   = N'($urandom);
        m_addr    = N'($urandom);
        m_wdata   = N'($urandom);
        bus_ready = 1'($urandom_range(0, 1));
        #2;
        total++;
        if ({bus_busy, m_bgnt, bus_valid, bus_addr, bus_wdata, m_ready, arb_timeout} !== '0) begin
            bad++;
            $display("FAIL idle_outputs cyc=%0d got busy=%b bgnt=%b valid=%b ready=%b to=%b exp=all_zero",
                     cyc, bus_busy, m_bgnt, bus_valid, m_ready, arb_timeout);
        end

        exp_own    = rr_model(req, exp_last);
        owner_seen = -1;
        if (exp_own < 0) return;
        eo = OW'(exp_own);

        next_cycle();
        m_breq  = N'($urandom);
        m_valid = N'($urandom);
        m_addr  = N'($urandom);
        m_wdata = N'($urandom);
        #2;
        total++;
        if (m_bgnt !== (N'(1) << exp_own) || bus_owner !== eo || bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL grant cyc=%0d got bgnt=%b owner=%0d busy=%b exp bgnt=%b owner=%0d busy=1",
                     cyc, m_bgnt, bus_owner, bus_busy, N'(1) << exp_own, exp_own);
        end
        total++;
        if ({bus_valid, bus_addr, bus_wdata, m_ready, arb_timeout} !== '0) begin
            bad++;
            $display("FAIL grant_bus_quiet cyc=%0d got valid=%b ready=%b to=%b exp=0",
                     cyc, bus_valid, m_ready, arb_timeout);
        end
        owner_seen = int'(bus_owner);

        exp_to = (delay >= GT);
        end_k  = exp_to ? GT - 1 : delay + len;
        for (int k = 0; k <= end_k; k++) begin
            next_cycle();
            m_breq      = N'($urandom);
            m_addr      = N'($urandom);
            m_wdata     = N'($urandom);
            m_valid     = N'($urandom);
            m_valid[eo] = (k >= delay) && (k < delay + len);
            case (ready_mode)
                0:       bus_ready = 1'b1;
                1:       bus_ready = 1'($urandom_range(0, 1));
                default: bus_ready = k[0];
            endcase
            exp_rdy = bus_ready ? (N'(1) << exp_own) : '0;
            #2;
            total++;
            if (bus_addr !== m_addr[eo] || bus_wdata !== m_wdata[eo] || bus_valid !== m_valid[eo]) begin
                bad++;
                $display("FAIL busy_mux cyc=%0d k=%0d got a/w/v=%b%b%b exp a/w/v=%b%b%b",
                         cyc, k, bus_addr, bus_wdata, bus_valid, m_addr[eo], m_wdata[eo], m_valid[eo]);
            end
            total++;
            if (m_ready !== exp_rdy || m_bgnt !== '0 || bus_busy !== 1'b1 || bus_owner !== eo) begin
                bad++;
                $display("FAIL busy_ctrl cyc=%0d k=%0d got ready=%b bgnt=%b busy=%b owner=%0d exp ready=%b bgnt=0 busy=1 owner=%0d",
                         cyc, k, m_ready, m_bgnt, bus_busy, bus_owner, exp_rdy, exp_own);
            end
            total++;
            if (arb_timeout !== (exp_to && (k == end_k))) begin
                bad++;
                $display("FAIL timeout_pulse cyc=%0d k=%0d got=%b exp=%b",
                         cyc, k, arb_timeout, exp_to && (k == end_k));
            end
        end
        exp_last = exp_own;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn      = 1'b0;
        m_breq    = '0;
        m_addr    = '0;
        m_wdata   = '0;
        m_valid   = '0;
        bus_ready = 1'b0;
        #2;
        total++;
        if ({m_bgnt, m_ready, bus_addr, bus_wdata, bus_valid, bus_owner, bus_busy, arb_timeout} !== '0
            || dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_outputs cyc=%0d got bgnt=%b ready=%b valid=%b owner=%0d busy=%b state=%0d exp=all_zero_idle",
                     cyc, m_bgnt, m_ready, bus_valid, bus_owner, bus_busy, dbg_state);
        end
        repeat (2) next_cycle();
        rstn     = 1'b1;
        exp_last = N - 1;
    endtask

    task automatic test_single_request();
        int got;
        run_xfer(2'b10, 0, 3, 0, got);
        total++;
        if (got !== 1) begin
            bad++;
            $display("FAIL single_owner cyc=%0d got=%0d exp=1", cyc, got);
        end
    endtask

    task automatic test_round_robin();
        logic [OW-1:0] exp_q[$];
        logic [OW-1:0] exp;
        int            got;
        exp_q.push_back(OW'(0));
        exp_q.push_back(OW'(1));
        exp_q.push_back(OW'(0));
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            run_xfer(2'b11, $urandom_range(0, 2), $urandom_range(1, 3), 1, got);
            total++;
            if (got !== int'(exp)) begin
                bad++;
                $display("FAIL rr_order cyc=%0d got=%0d exp=%0d", cyc, got, exp);
            end
        end
    endtask

    task automatic test_ready_routing();
        int got;
        run_xfer(2'b01, 1, 5, 2, got);
    endtask

    task automatic test_timeout();
        int got;
        run_xfer(2'b01, 0, 1, 1, got);
        run_xfer(2'b11, GT + 5, 1, 1, got);
        total++;
        if (got !== 1) begin
            bad++;
            $display("FAIL timeout_owner cyc=%0d got=%0d exp=1", cyc, got);
        end
        run_xfer(2'b01, GT - 1, 2, 1, got);
        total++;
        if (got !== 0) begin
            bad++;
            $display("FAIL after_timeout_owner cyc=%0d got=%0d exp=0", cyc, got);
        end
    endtask

    task automatic test_idle_hold();
        next_cycle();
        m_breq  = '0;
        m_valid = '1;
        repeat (3) begin
            next_cycle();
            #2;
            total++;
            if (bus_busy !== 1'b0 || m_bgnt !== '0 || bus_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got busy=%b bgnt=%b valid=%b exp=0", cyc, bus_busy, m_bgnt, bus_valid);
            end
        end
    endtask

    task automatic test_random();
        int got;
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] req;
            req = N'($urandom_range(1, (1 << N) - 1));
            run_xfer(req, $urandom_range(0, GT), $urandom_range(1, 4), 1, got);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int got;
        next_cycle();
        m_breq  = 2'b01;
        m_valid = '0;
        next_cycle();
        m_breq = '0;
        next_cycle();
        m_valid   = 2'b11;
        m_addr    = 2'b11;
        m_wdata   = 2'b11;
        bus_ready = 1'b1;
        #2;
        total++;
        if (bus_valid !== 1'b1 || bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_busy cyc=%0d got valid=%b busy=%b exp=1/1", cyc, bus_valid, bus_busy);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({m_bgnt, m_ready, bus_addr, bus_wdata, bus_valid, bus_owner, bus_busy, arb_timeout} !== '0) begin
            bad++;
            $display("FAIL async_reset cyc=%0d got bgnt=%b ready=%b a/w/v=%b%b%b busy=%b to=%b exp=all_zero",
                     cyc, m_bgnt, m_ready, bus_addr, bus_wdata, bus_valid, bus_busy, arb_timeout);
        end
        next_cycle();
        m_breq  = '0;
        m_valid = '0;
        rstn    = 1'b1;
        exp_last = N - 1;
        run_xfer(2'b11, 0, 2, 0, got);
        total++;
        if (got !== 0) begin
            bad++;
            $display("FAIL post_reset_owner cyc=%0d got=%0d exp=0", cyc, got);
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_ready_routing();
        test_timeout();
        test_idle_hold();
        test_random();
        test_reset_mid_transfer();
        test_idle_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the serial system bus. It shares one slave-side bus between `NUM_MASTERS` master ports using round-robin arbitration on `m_breq`. It issues a one-cycle `m_bgnt` to the winner and steers the winner's serial address, write data and valid onto the shared bus. It routes the slave `bus_ready` back to the owner only, and reclaims the bus when the owner's transfer ends or the owner fails to start.

## Interface

Parameters:
- `NUM_MASTERS`, default 2: number of master ports (≥2).
- `GNT_TIMEOUT`, default 8: cycles the owner may take, after entering BUSY, to assert valid before the bus is reclaimed.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `m_breq`  in  `NUM_MASTERS`: bus request, one bit per master.
- `m_bgnt`  out  `NUM_MASTERS`: bus grant, one-hot, one-cycle pulse.
- `m_addr`  in  `NUM_MASTERS`: serial address bit from each master.
- `m_wdata`  in  `NUM_MASTERS`: serial write-data bit from each master.
- `m_valid`  in  `NUM_MASTERS`: per-master valid.
- `m_ready`  out  `NUM_MASTERS`: `bus_ready` routed to the owner; 0 for non-owners.
- `bus_addr`  out  1: muxed serial address bit.
- `bus_wdata`  out  1: muxed serial write-data bit.
- `bus_valid`  out  1: muxed valid.
- `bus_ready`  in  1: slave-side ready.
- `bus_owner`  out  `$clog2(NUM_MASTERS)`: index of the current owner.
- `bus_busy`  out  1: high in GRANT or BUSY.
- `arb_timeout`  out  1: one-cycle pulse when a grant is reclaimed by timeout.

## Operation

States are IDLE, GRANT and BUSY.
- **IDLE:**
  - If any `m_breq` bit is set, pick the winner by round-robin, starting the search at `last_owner+1` and wrapping modulo `NUM_MASTERS`.
  - Register the winner in `owner` and go to GRANT.
  - If no request is set, stay in IDLE.
- **GRANT:** assert `m_bgnt[owner]=1` (Moore, from registered state) for exactly one cycle, then go to BUSY unconditionally.
- **BUSY:**
  - `bus_addr`, `bus_wdata` and `bus_valid` equal the owner's `m_addr`, `m_wdata` and `m_valid` combinationally, with zero latency.
  - `m_ready[owner]` equals `bus_ready`.
  - A `seen_valid` flag sets on the first cycle `m_valid[owner]=1`.
  - Release: when `seen_valid` is set and `m_valid[owner]=0`, go to IDLE and set `last_owner <= owner`.
  - Timeout: the counter starts at 0 on BUSY entry and increments each cycle while `seen_valid` is 0. When it reaches `GNT_TIMEOUT-1` with valid still low, pulse `arb_timeout` and go to IDLE, setting `last_owner <= owner`.
  - Once `seen_valid` is set, there is no timeout; the owner holds the bus until valid drops.
- **Outside BUSY:** `bus_addr`, `bus_wdata` and `bus_valid` are 0, all `m_ready` bits are 0, and `m_bgnt` is 0 except in GRANT.
- `m_breq` from the owner or from other masters during GRANT/BUSY is ignored. It is re-evaluated only in IDLE.
- Width rules:
  - `owner` and `last_owner` are `$clog2(NUM_MASTERS)` bits.
  - The timeout counter is `$clog2(GNT_TIMEOUT+1)` bits and saturates; it never wraps.

## Timing

- Reset values (async, immediate):
  - State IDLE.
  - `owner=0`, `last_owner=NUM_MASTERS-1`, so master 0 has first priority.
  - Counter 0, `seen_valid=0`.
  - All outputs 0.
- Grant latency: request seen in IDLE at cycle t → `m_bgnt` high at t+1 → BUSY at t+2. This matches the master entering its transfer state at t+2.
- Release latency: owner valid low at cycle r → IDLE at r+1 → next grant no earlier than r+2. There is one arbitration cycle minimum between owners.
- Simultaneous requests in IDLE: round-robin decides; exactly one grant bit is set.
- A valid rising and falling within BUSY on consecutive cycles is a normal release.
- Reset mid-transfer: the bus drops immediately, all outputs go to 0, and there is no timeout pulse.

## Structure

- Package `bus_pkg` holds:
  - `arb_state_t` (IDLE, GRANT, BUSY).
  - Default `NUM_MASTERS` and `GNT_TIMEOUT` constants.
- One sub-module, `rr_pick`: combinational round-robin priority select, taking the request vector and `last_owner` and returning `any` plus the winner index.
- The rest is flat in `bus_arbiter`: the FSM, the owner/`last_owner` registers, the timeout counter and the output mux.

## Test plan

- **Reset then single request:** `m_breq=2'b10` → `m_bgnt=2'b10` one cycle after request, `bus_owner=1`, `bus_busy=1`. Owner's `m_valid` and `m_addr` appear on `bus_valid` and `bus_addr` in the same cycle.
- **Simultaneous requests from reset:** `m_breq=2'b11` held → grants alternate 0, 1, 0, each after the previous owner drops valid. There is a one-cycle IDLE gap between owners.
- **Ready routing:** owner 0 in BUSY with `bus_ready=1` → `m_ready=2'b01`. With `bus_ready=0` → `m_ready=2'b00`. Non-owner `m_valid=1` never reaches `bus_valid`.
- **Timeout:** grant master 1, which never asserts valid, with `GNT_TIMEOUT=8` → `arb_timeout` pulses on the 8th BUSY cycle, then IDLE. A pending `m_breq[0]` is granted next.
- **Reset mid-transfer:** drop `rstn` during BUSY with valid high → all outputs go to 0 asynchronously. After reset release, `m_breq=2'b11` grants master 0 first.
